// File: rtl/bus_ctrl.sv
// bus_ctrl: single-master bus controller between the cpu bus master port and
// NSLAVE slaves. It registers each request, decodes the slave number into a
// one-hot select, waits for the selected slave's ack with a timeout, and
// returns a one-cycle ready pulse with read data or an error flag.
module bus_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned SLAVE_WIDTH = 4,
    parameter int unsigned NSLAVE      = 4,
    parameter int unsigned TIMEOUT     = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m_req,
    input  logic                          m_wen,
    input  logic [2:0]                    m_mode,
    input  logic [SLAVE_WIDTH-1:0]        m_num,
    input  logic [XLEN-SLAVE_WIDTH-1:0]   m_addr,
    input  logic [XLEN-1:0]               m_dat_i,
    output logic [XLEN-1:0]               m_dat_o,
    output logic                          m_ready,
    output logic                          m_err,
    output logic [NSLAVE-1:0]             s_sel,
    output logic                          s_wen,
    output logic [2:0]                    s_mode,
    output logic [XLEN-SLAVE_WIDTH-1:0]   s_addr,
    output logic [XLEN-1:0]               s_dat_o,
    input  logic [NSLAVE*XLEN-1:0]        s_dat_i,
    input  logic [NSLAVE-1:0]             s_ack,
    output logic [7:0]                    err_cnt
);

    localparam int unsigned AW = XLEN - SLAVE_WIDTH;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [NSLAVE-1:0] s_sel_q, s_sel_d;
    logic              s_wen_q, s_wen_d;
    logic [2:0]        s_mode_q, s_mode_d;
    logic [AW-1:0]     s_addr_q, s_addr_d;
    logic [XLEN-1:0]   s_dat_o_q, s_dat_o_d;
    logic [XLEN-1:0]   m_dat_o_q, m_dat_o_d;
    logic              m_ready_q, m_ready_d;
    logic              m_err_q, m_err_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [NSLAVE-1:0] sel_dec;
    logic              num_ok;
    logic              ack_hit;
    logic [XLEN-1:0]   rd_mux;

    // One-hot decode; an out-of-range number shifts the bit out, leaving zero
    always_comb begin
        sel_dec = NSLAVE'(1) << m_num;
        num_ok  = |sel_dec;
        ack_hit = |(s_ack & s_sel_q);
    end

    // Read-data slice of the currently selected slave
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < int'(NSLAVE); k++) begin
            if (s_sel_q[k]) begin
                rd_mux = rd_mux | s_dat_i[k*XLEN +: XLEN];
            end
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d   = state_q;
        s_sel_d   = s_sel_q;
        s_wen_d   = s_wen_q;
        s_mode_d  = s_mode_q;
        s_addr_d  = s_addr_q;
        s_dat_o_d = s_dat_o_q;
        m_dat_o_d = m_dat_o_q;
        m_ready_d = 1'b0;
        m_err_d   = 1'b0;
        wait_d    = wait_q;
        err_cnt_d = err_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    s_wen_d   = m_wen;
                    s_mode_d  = m_mode;
                    s_addr_d  = m_addr;
                    s_dat_o_d = m_dat_i;
                    if (num_ok) begin
                        s_sel_d = sel_dec;
                        wait_d  = '0;
                        state_d = ST_ACCESS;
                    end else begin
                        m_dat_o_d = '0;
                        m_ready_d = 1'b1;
                        m_err_d   = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is checked before the timeout so a last-cycle ack still succeeds
                if (ack_hit) begin
                    m_dat_o_d = s_wen_q ? '0 : rd_mux;
                    m_ready_d = 1'b1;
                    s_sel_d   = '0;
                    state_d   = ST_RESP;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    m_dat_o_d = '0;
                    m_ready_d = 1'b1;
                    m_err_d   = 1'b1;
                    s_sel_d   = '0;
                    state_d   = ST_RESP;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (m_err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                s_sel_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            s_sel_q   <= '0;
            s_wen_q   <= 1'b0;
            s_mode_q  <= '0;
            s_addr_q  <= '0;
            s_dat_o_q <= '0;
            m_dat_o_q <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            wait_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            s_sel_q   <= s_sel_d;
            s_wen_q   <= s_wen_d;
            s_mode_q  <= s_mode_d;
            s_addr_q  <= s_addr_d;
            s_dat_o_q <= s_dat_o_d;
            m_dat_o_q <= m_dat_o_d;
            m_ready_q <= m_ready_d;
            m_err_q   <= m_err_d;
            wait_q    <= wait_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign m_dat_o = m_dat_o_q;
    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;
    assign s_sel   = s_sel_q;
    assign s_wen   = s_wen_q;
    assign s_mode  = s_mode_q;
    assign s_addr  = s_addr_q;
    assign s_dat_o = s_dat_o_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Testbench for bus_ctrl: directed and randomized transactions checked against
// a transaction-level model (latency, error flag, read data, error count).
module tb_bus_ctrl;

    localparam int XLEN = 32;
    localparam int SW   = 4;
    localparam int NS   = 4;
    localparam int TO   = 15;
    localparam int AW   = XLEN - SW;

    logic              clk;
    logic              rst;
    logic              m_req;
    logic              m_wen;
    logic [2:0]        m_mode;
    logic [SW-1:0]     m_num;
    logic [AW-1:0]     m_addr;
    logic [XLEN-1:0]   m_dat_i;
    logic [XLEN-1:0]   m_dat_o;
    logic              m_ready;
    logic              m_err;
    logic [NS-1:0]     s_sel;
    logic              s_wen;
    logic [2:0]        s_mode;
    logic [AW-1:0]     s_addr;
    logic [XLEN-1:0]   s_dat_o;
    logic [NS*XLEN-1:0] s_dat_i;
    logic [NS-1:0]     s_ack;
    logic [7:0]        err_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [XLEN-1:0] slv_dat [NS];

    bus_ctrl #(.XLEN(XLEN), .SLAVE_WIDTH(SW), .NSLAVE(NS), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_wen(m_wen), .m_mode(m_mode), .m_num(m_num),
        .m_addr(m_addr), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
        .m_ready(m_ready), .m_err(m_err),
        .s_sel(s_sel), .s_wen(s_wen), .s_mode(s_mode), .s_addr(s_addr),
        .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction; d = cycle of the slave ack after the request edge (0 = never)
    task automatic run_txn(input logic wen, input logic [2:0] mode, input logic [SW-1:0] num,
                           input logic [AW-1:0] addr, input logic [XLEN-1:0] wdat,
                           input int d, input bit stray);
        int              lat;
        logic            exp_err;
        logic [XLEN-1:0] exp_dat;
        logic [NS-1:0]   exp_sel;
        logic [NS-1:0]   rnd;
        bit              done;
        bit              good_num;

        good_num = int'(num) < NS;
        exp_sel  = good_num ? (NS'(1) << num) : '0;
        if (!good_num) begin
            lat = 1; exp_err = 1'b1;
        end else if (d >= 1 && d <= TO) begin
            lat = d + 1; exp_err = 1'b0;
        end else begin
            lat = TO + 1; exp_err = 1'b1;
        end
        exp_dat = (exp_err || wen) ? '0 : slv_dat[good_num ? int'(num) : 0];

        for (int k = 0; k < NS; k++) s_dat_i[k*XLEN +: XLEN] = slv_dat[k];
        m_req = 1'b1; m_wen = wen; m_mode = mode; m_num = num;
        m_addr = addr; m_dat_i = wdat; s_ack = '0;

        done = 0;
        for (int j = 0; j < 40 && !done; j++) begin
            @(posedge clk); #1;
            if (j == 0) begin
                total++;
                if (s_wen !== wen || s_mode !== mode || s_addr !== addr || s_dat_o !== wdat) begin
                    bad++;
                    $display("FAIL s_regs: got wen=%b mode=%0d addr=%h dat=%h want wen=%b mode=%0d addr=%h dat=%h",
                             s_wen, s_mode, s_addr, s_dat_o, wen, mode, addr, wdat);
                end
            end
            if (m_ready === 1'b1) begin
                done = 1;
                total++;
                if (j + 1 != lat) begin
                    bad++;
                    $display("FAIL latency: got %0d want %0d (num=%0d d=%0d)", j + 1, lat, num, d);
                end
                total++;
                if (m_err !== exp_err) begin
                    bad++;
                    $display("FAIL m_err: got %b want %b", m_err, exp_err);
                end
                total++;
                if (m_dat_o !== exp_dat) begin
                    bad++;
                    $display("FAIL m_dat_o: got %h want %h", m_dat_o, exp_dat);
                end
                total++;
                if (s_sel !== '0) begin
                    bad++;
                    $display("FAIL s_sel_in_resp: got %b want 0", s_sel);
                end
                m_req = 1'b0;
                s_ack = '0;
            end else begin
                if (j + 1 < lat) begin
                    total++;
                    if (s_sel !== exp_sel) begin
                        bad++;
                        $display("FAIL s_sel: got %b want %b (cycle %0d)", s_sel, exp_sel, j);
                    end
                end
                rnd = stray ? NS'($urandom) : '0;
                rnd = rnd & ~exp_sel;
                if (d > 0 && j + 1 == d) rnd = rnd | exp_sel;
                s_ack = rnd;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL ready_timeout: got no m_ready want latency %0d", lat);
            m_req = 1'b0;
            s_ack = '0;
        end
        if (exp_err && exp_cnt < 255) exp_cnt++;
        @(posedge clk); #1;
        total++;
        if (m_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_pulse: got %b want 0", m_ready);
        end
        total++;
        if (int'(err_cnt) != exp_cnt) begin
            bad++;
            $display("FAIL err_cnt: got %0d want %0d", err_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; m_req = 1'b0; m_wen = 1'b0; m_mode = '0; m_num = '0;
        m_addr = '0; m_dat_i = '0; s_dat_i = '0; s_ack = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (m_dat_o !== '0 || m_ready !== 1'b0 || m_err !== 1'b0 || s_sel !== '0 ||
            s_wen !== 1'b0 || s_mode !== '0 || s_addr !== '0 || s_dat_o !== '0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got dat=%h rdy=%b err=%b sel=%b wen=%b mode=%0d addr=%h wd=%h cnt=%0d want all 0",
                     m_dat_o, m_ready, m_err, s_sel, s_wen, s_mode, s_addr, s_dat_o, err_cnt);
        end
        rst = 1'b1;
        exp_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_basic();
        for (int k = 0; k < NS; k++) slv_dat[k] = $urandom;
        slv_dat[2] = 32'h1234_5678;
        run_txn(1'b0, 3'd2, 4'd2, 28'h0000_040, 32'h0, 1, 1'b0);
    endtask

    task automatic test_write_wait();
        run_txn(1'b1, 3'd1, 4'd1, 28'h0000_010, 32'hCAFE_F00D, 4, 1'b1);
    endtask

    task automatic test_bad_slave();
        run_txn(1'b0, 3'd0, 4'd7, 28'h0000_020, 32'h0, 1, 1'b1);
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 3'd4, 4'd0, 28'h0000_100, 32'h0, 0, 1'b1);
    endtask

    task automatic test_ack_last();
        slv_dat[3] = 32'hA5A5_0FF0;
        run_txn(1'b0, 3'd3, 4'd3, 28'h0ABC_DEF, 32'h0, TO, 1'b1);
    endtask

    task automatic test_back_to_back();
        slv_dat[0] = 32'h0BAD_CAFE;
        slv_dat[3] = 32'h7777_1111;
        run_txn(1'b0, 3'd2, 4'd0, 28'h0000_004, 32'h0, 1, 1'b0);
        run_txn(1'b0, 3'd2, 4'd3, 28'h0000_008, 32'h0, 2, 1'b0);
    endtask

    task automatic test_random();
        logic [SW-1:0] num;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < NS; k++) slv_dat[k] = $urandom;
            num = ($urandom_range(0, 5) == 0) ? SW'($urandom_range(4, 15)) : SW'($urandom_range(0, 3));
            run_txn(1'($urandom), 3'($urandom), num, AW'($urandom), $urandom,
                    int'($urandom_range(0, 17)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_access();
        bit seen;
        m_req = 1'b1; m_wen = 1'b0; m_mode = 3'd2; m_num = 4'd1;
        m_addr = 28'h0000_0C0; m_dat_i = '0; s_ack = '0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (s_sel !== 4'b0010) begin
            bad++;
            $display("FAIL mid_sel: got %b want 0010", s_sel);
        end
        rst = 1'b0; m_req = 1'b0;
        @(posedge clk); #1;
        total++;
        if (s_sel !== '0 || m_ready !== 1'b0 || err_cnt !== '0) begin
            bad++;
            $display("FAIL mid_reset: got sel=%b rdy=%b cnt=%0d want 0 0 0", s_sel, m_ready, err_cnt);
        end
        rst = 1'b1;
        exp_cnt = 0;
        seen = 0;
        for (int j = 0; j < 20; j++) begin
            @(posedge clk); #1;
            if (m_ready === 1'b1) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_no_ready: got m_ready after reset want none");
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b0, 3'd0, SW'($urandom_range(4, 15)), AW'($urandom), 32'h0, 1, 1'b1);
        end
        total++;
        if (err_cnt !== 8'd255) begin
            bad++;
            $display("FAIL saturate: got %0d want 255", err_cnt);
        end
        slv_dat[1] = 32'h5555_AAAA;
        run_txn(1'b0, 3'd0, 4'd1, 28'h0000_001, 32'h0, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wait();
        test_bad_slave();
        test_timeout();
        test_ack_last();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
